// File: rtl/stack_arbiter_if.sv
// Request/response bus between NREQ client requesters and the stack arbiter.
//   req_valid  [NREQ]        : requester i has a command pending
//   req_op     [2*NREQ]      : per-requester op, 00 push / 01 pop / 10 peek / 11 illegal
//   req_data   [WIDTH*NREQ]  : per-requester push data
//   req_ack    [NREQ]        : one-hot 1-cycle pulse, command of requester i accepted
//   resp_valid               : 1-cycle pulse, response fields valid
//   resp_id    [IDW]         : requester being answered
//   resp_data  [WIDTH]       : pop/peek data, 0 for push or error
//   resp_err                 : command refused
// master = client side, slave = arbiter side.
interface stack_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_data;
    logic [NREQ-1:0]       req_ack;
    logic                  resp_valid;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_err;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ack, resp_valid, resp_id, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ack, resp_valid, resp_id, resp_data, resp_err
    );
endinterface

// File: rtl/stack_arbiter.sv
// Shares one stack among NREQ requesters. Commands are granted round-robin one at
// a time; each accepted command gets exactly one response (data or error flag).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus           : stack_arbiter_if.slave request/response bus
//   stk_instr     : stack instruction, 11 = NOP while idle
//   stk_data_in   : stack push data
//   stk_data_out  : stack read data (registered inside the stack)
//   stk_empty     : stack empty flag
//   stk_full      : stack full flag
// All outputs are registered. Sequence per command: IDLE -> ISSUE -> SETTLE -> IDLE.
module stack_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic             clk,
    input  logic             reset,
    stack_arbiter_if.slave   bus,
    output logic [1:0]       stk_instr,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_empty,
    input  logic             stk_full
);
    localparam int unsigned IDW = $clog2(NREQ);

    localparam logic [1:0] OpPush = 2'b00;
    localparam logic [1:0] OpPop  = 2'b01;
    localparam logic [1:0] OpPeek = 2'b10;
    localparam logic [1:0] OpNop  = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StSettle} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic [1:0]       instr_q, instr_d;
    logic [WIDTH-1:0] data_in_q, data_in_d;
    logic [1:0]       op_q, op_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             err_q, err_d;

    logic [IDW-1:0]   win;
    logic             any_req;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_data;
    logic             cmd_err;

    // Round-robin pick: first pending requester after the last winner, with wrap.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!any_req && bus.req_valid[IDW'((32'(ptr_q) + k) % NREQ)]) begin
                win     = IDW'((32'(ptr_q) + k) % NREQ);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        sel_op   = OpNop;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                sel_op   = bus.req_op[2*i +: 2];
                sel_data = bus.req_data[WIDTH*i +: WIDTH];
            end
        end
    end

    // Flags are stable in IDLE because no stack op is in flight.
    assign cmd_err = (sel_op == OpNop) ||
                     ((sel_op == OpPush) && stk_full) ||
                     (((sel_op == OpPop) || (sel_op == OpPeek)) && stk_empty);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        ack_d        = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        instr_d      = instr_q;
        data_in_d    = data_in_q;
        op_d         = op_q;
        id_d         = id_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    ack_d     = NREQ'(1) << win;
                    ptr_d     = win;
                    op_d      = sel_op;
                    id_d      = win;
                    data_in_d = sel_data;
                    err_d     = cmd_err;
                    // Refused commands never reach the stack but still use a slot.
                    instr_d   = cmd_err ? OpNop : sel_op;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                // Stack executes on this edge; drop back to NOP so it runs once.
                instr_d = OpNop;
                state_d = StSettle;
            end
            StSettle: begin
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                resp_err_d   = err_q;
                resp_data_d  = (!err_q && (op_q != OpPush)) ? stk_data_out : '0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= IDW'(NREQ - 1);
            ack_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            instr_q      <= OpNop;
            data_in_q    <= '0;
            op_q         <= OpNop;
            id_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ack_q        <= ack_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            instr_q      <= instr_d;
            data_in_q    <= data_in_d;
            op_q         <= op_d;
            id_q         <= id_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ack    = ack_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign stk_instr      = instr_q;
    assign stk_data_in    = data_in_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural 16-deep stack, table of serial commands,
// hand sequences for multi-requester arbitration, overflow and mid-op reset.
module tb_stack_arbiter;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    logic [1:0] stk_instr;
    logic [7:0] stk_data_in;
    logic [7:0] stk_data_out;
    logic       stk_empty;
    logic       stk_full;

    stack_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .stk_instr    (stk_instr),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_empty    (stk_empty),
        .stk_full     (stk_full)
    );

    // Behavioural stack sharing the reset net.
    logic [7:0] mem [DEPTH];
    logic [4:0] sp;
    always_ff @(posedge clk) begin
        if (reset) begin
            sp           <= '0;
            stk_data_out <= '0;
        end else begin
            case (stk_instr)
                2'b00: if (sp < 5'(DEPTH)) begin
                    mem[sp[3:0]] <= stk_data_in;
                    sp           <= sp + 5'd1;
                end
                2'b01: if (sp != 5'd0) begin
                    stk_data_out <= mem[sp[3:0] - 4'd1];
                    sp           <= sp - 5'd1;
                end
                2'b10: if (sp != 5'd0) stk_data_out <= mem[sp[3:0] - 4'd1];
                default: ;
            endcase
        end
    end
    assign stk_empty = (sp == 5'd0);
    assign stk_full  = (sp == 5'(DEPTH));

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
    } resp_t;

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] data;
        logic       err;
        logic [7:0] rdata;
    } vec_t;

    resp_t      exp_q[$];
    logic [7:0] ref_stk[$];
    int         checks = 0;
    int         errors = 0;
    int         instr_cycles = 0;
    int         exp_instr_cycles = 0;
    int         rr_ptr = NREQ - 1;
    logic [3:0] pend;
    logic [1:0] cmd_op [NREQ];
    logic [7:0] cmd_data [NREQ];
    vec_t       tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response scoreboard plus stack-instruction sanity.
    initial begin
        logic  prev_legal;
        resp_t e;
        prev_legal = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.resp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_id", 32'(bus.resp_id), 32'(e.id));
                        check("resp_data", 32'(bus.resp_data), 32'(e.data));
                        check("resp_err", 32'(bus.resp_err), 32'(e.err));
                    end
                end
                if (bus.req_ack != '0) check("ack_onehot", 32'($onehot(bus.req_ack)), 32'd1);
                if (stk_instr != 2'b11) begin
                    instr_cycles++;
                    check("instr_repeat", 32'(prev_legal), 32'd0);
                end
                prev_legal = (stk_instr != 2'b11);
            end else begin
                prev_legal = 1'b0;
            end
        end
    end

    task automatic model_step(input logic [1:0] op, input logic [7:0] data,
                              output logic e, output logic [7:0] d);
        e = 1'b0;
        d = 8'h00;
        case (op)
            2'b00: if (ref_stk.size() == DEPTH) e = 1'b1; else ref_stk.push_back(data);
            2'b01: if (ref_stk.size() == 0) e = 1'b1; else d = ref_stk.pop_back();
            2'b10: if (ref_stk.size() == 0) e = 1'b1; else d = ref_stk[$];
            default: e = 1'b1;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ref_stk.delete();
        exp_q.delete();
        rr_ptr = NREQ - 1;
    endtask

    task automatic check_reset_outputs();
        check("rst_ack", 32'(bus.req_ack), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_id", 32'(bus.resp_id), 32'd0);
        check("rst_resp_data", 32'(bus.resp_data), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_stk_instr", 32'(stk_instr), 32'd3);
        check("rst_stk_data_in", 32'(stk_data_in), 32'd0);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Single requester command, blocks until its response.
    task automatic do_cmd(input int id, input logic [1:0] op, input logic [7:0] data,
                          input logic exp_err, input logic [7:0] exp_data);
        bit got;
        int lat;
        bus.req_valid = '0;
        bus.req_valid[id] = 1'b1;
        bus.req_op[2*id +: 2] = op;
        bus.req_data[8*id +: 8] = data;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = (bus.req_ack != '0);
        end
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
            bus.req_valid = '0;
            return;
        end
        check("ack_id", 32'(bus.req_ack), 32'd1 << id);
        exp_q.push_back('{id: 2'(id), data: exp_data, err: exp_err});
        if (!exp_err) exp_instr_cycles++;
        bus.req_valid = '0;
        got = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                lat = k;
            end
        end
        check("resp_latency", 32'(lat), 32'd2);
    endtask

    task automatic model_cmd(input int id, input logic [1:0] op, input logic [7:0] data);
        logic       e;
        logic [7:0] d;
        model_step(op, data, e, d);
        do_cmd(id, op, data, e, d);
    endtask

    // Present cmd_op/cmd_data for every requester in pend, observe ngrants grants.
    task automatic grant_seq(input int ngrants, input bit hold);
        bit         got;
        int         pred;
        logic       e;
        logic [7:0] d;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_op[2*i +: 2] = cmd_op[i];
            bus.req_data[8*i +: 8] = cmd_data[i];
        end
        bus.req_valid = pend;
        for (int g = 0; g < ngrants; g++) begin
            pred = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (pred < 0 && pend[(rr_ptr + k) % NREQ]) pred = (rr_ptr + k) % NREQ;
            end
            got = 1'b0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = (bus.req_ack != '0);
            end
            if (!got || pred < 0) begin
                check("grant_timeout", 32'd0, 32'd1);
                break;
            end
            check("grant_order", 32'(bus.req_ack), 32'd1 << pred);
            model_step(cmd_op[pred], cmd_data[pred], e, d);
            exp_q.push_back('{id: 2'(pred), data: d, err: e});
            if (!e) exp_instr_cycles++;
            rr_ptr = pred;
            if (!hold) begin
                pend[pred] = 1'b0;
                bus.req_valid[pred] = 1'b0;
            end
        end
        bus.req_valid = '0;
        pend = '0;
        wait_drain();
    endtask

    initial begin
        int base;
        bit got;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_op = '0;
        bus.req_data = '0;
        pend = '0;

        tbl[0] = '{0, 2'b00, 8'hA5, 1'b0, 8'h00};
        tbl[1] = '{0, 2'b01, 8'h00, 1'b0, 8'hA5};
        tbl[2] = '{2, 2'b01, 8'h00, 1'b1, 8'h00};
        tbl[3] = '{1, 2'b11, 8'h42, 1'b1, 8'h00};
        tbl[4] = '{3, 2'b10, 8'h00, 1'b1, 8'h00};
        tbl[5] = '{1, 2'b00, 8'h3C, 1'b0, 8'h00};
        tbl[6] = '{2, 2'b10, 8'h00, 1'b0, 8'h3C};
        tbl[7] = '{3, 2'b01, 8'h00, 1'b0, 8'h3C};

        do_reset();
        @(negedge clk);
        check_reset_outputs();

        for (int i = 0; i < 8; i++) begin
            do_cmd(tbl[i].id, tbl[i].op, tbl[i].data, tbl[i].err, tbl[i].rdata);
        end
        wait_drain();

        // Pop on an empty stack must never drive the stack.
        do_reset();
        base = instr_cycles;
        do_cmd(2, 2'b01, 8'h00, 1'b1, 8'h00);
        check("err_no_instr", 32'(instr_cycles), 32'(base));

        // Four pushes held together: grants 0,1,2,3, then LIFO pops.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            cmd_op[i] = 2'b00;
            cmd_data[i] = 8'h10 + 8'(i);
        end
        pend = 4'b1111;
        grant_seq(4, 1'b0);
        for (int i = 0; i < NREQ; i++) model_cmd(i, 2'b01, 8'h00);

        // Overflow, then peeks see the top without consuming it.
        do_reset();
        for (int i = 0; i < 16; i++) model_cmd(0, 2'b00, 8'h20 + 8'(i));
        check("stack_full", 32'(stk_full), 32'd1);
        do_cmd(0, 2'b00, 8'hEE, 1'b1, 8'h00);
        do_cmd(1, 2'b10, 8'h00, 1'b0, 8'h2F);
        do_cmd(1, 2'b10, 8'h00, 1'b0, 8'h2F);
        ref_stk.delete();

        // Illegal op from req1 alternating with pushes from req3.
        do_reset();
        cmd_op[1] = 2'b11;
        cmd_data[1] = 8'h00;
        cmd_op[3] = 2'b00;
        cmd_data[3] = 8'h55;
        pend = 4'b1010;
        grant_seq(4, 1'b1);

        // Reset during ISSUE drops the command.
        do_reset();
        bus.req_op[1:0] = 2'b00;
        bus.req_data[7:0] = 8'h77;
        bus.req_valid = 4'b0001;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = (bus.req_ack != '0);
        end
        check("midreset_ack", 32'(got), 32'd1);
        check("midreset_instr", 32'(stk_instr), 32'd0);
        if (got) exp_instr_cycles++;
        reset = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        check_reset_outputs();
        check("midreset_empty", 32'(stk_empty), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        ref_stk.delete();
        rr_ptr = NREQ - 1;
        repeat (6) @(negedge clk);

        check("instr_cycles", 32'(instr_cycles), 32'(exp_instr_cycles));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
